// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester lanes plus FIFO write-port signals shared through the arbiter
interface fifo_wr_arbiter_if #(
  parameter int MEMORY_WIDTH = 4,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic [N_REQ*MEMORY_WIDTH-1:0] data_in;
  logic full;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic w_en;
  logic [MEMORY_WIDTH-1:0] WR;
  modport master(output req, last, data_in, full, input gnt, ack, w_en, WR);
  modport slave(input req, last, data_in, full, output gnt, ack, w_en, WR);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ requesters
module fifo_wr_arbiter #(
  parameter int MEMORY_WIDTH = 4,
  parameter int N_REQ = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] prio, owner, pick;
  logic [CW-1:0] burst_cnt;
  logic accept, done;
  // downward scan so the lowest offset from prio wins
  always_comb begin
    pick = prio;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req[IW'((int'(prio) + i) % N_REQ)]) pick = IW'((int'(prio) + i) % N_REQ);
  end
  always_comb begin
    accept = state == BUSY && bus.req[owner] && !bus.full;
    done = accept && (bus.last[owner] || burst_cnt == CW'(MAX_BURST - 1));
    bus.w_en = accept;
    bus.ack = accept ? N_REQ'(1) << owner : '0;
    bus.gnt = state == BUSY ? N_REQ'(1) << owner : '0;
    bus.WR = state == BUSY ? bus.data_in[owner*MEMORY_WIDTH +: MEMORY_WIDTH] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      prio <= '0;
      owner <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        state <= BUSY;
        owner <= pick;
        burst_cnt <= '0;
      end
    end else if (accept) begin
      burst_cnt <= burst_cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        prio <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule
